// File: rtl/somador_serial_if.sv
// -----------------------------------------------------------------------------
// somador_serial_if
//   Handshake and data bundle for the serial adder somador_serial.
//   Input side : in_valid/in_ready handshake carrying operands a, b and cin.
//   Output side: out_valid/out_ready handshake carrying sum and cout.
//   busy is a status flag (high while an operation is in flight).
//   When SOMADOR_SERIAL_OVF_EN is defined, a signed-overflow flag ovf is
//   carried alongside cout.
//   Modports:
//     master - the producer/consumer around the adder (testbench, host logic)
//     slave  - the adder itself
// -----------------------------------------------------------------------------
interface somador_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef SOMADOR_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/somador_serial.sv
// -----------------------------------------------------------------------------
// somador_serial
//   Multi-cycle ripple-carry adder: computes a + b + cin (modulo 2^WIDTH) plus
//   carry-out, DIGIT bits per clock, through a registered carry chain.
//
// Parameters
//   WIDTH - operand/sum width in bits (>= 2)
//   DIGIT - bits added per cycle; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - somador_serial_if.slave:
//            in_valid/in_ready, a, b, cin   operand handshake (ready only idle)
//            out_valid/out_ready, sum, cout result handshake (held until taken)
//            busy                           high while computing or holding
//            ovf                            signed overflow (optional, below)
//
// Configuration
//   SOMADOR_SERIAL_OVF_EN - when defined, bus.ovf reports signed overflow
//   (carry into the MSB XOR carry out), registered together with cout.
//
// Timing
//   Operands are latched on the accept edge. WIDTH/DIGIT CALC cycles follow,
//   one digit each, then one more edge moves the result into DONE, so
//   out_valid rises WIDTH/DIGIT+1 cycles after the accept edge.
// -----------------------------------------------------------------------------
module somador_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    somador_serial_if.slave  bus
);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
            $error("somador_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One digit of the ripple chain: DIGIT-bit operands plus carry, result
    // one bit wider so the top bit is the outgoing carry.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic             cmsb_q, cmsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
`ifdef SOMADOR_SERIAL_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif
        dsum    = '0;
        sum_cat = '0;

        unique case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (bus.in_valid) begin
                    state_d = CALC;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                end
            end

            CALC: begin
                if (count_q == NDIG_C) begin
                    // All digits done: publish the final carry with the sum.
                    state_d = DONE;
                    cout_d  = carry_q;
`ifdef SOMADOR_SERIAL_OVF_EN
                    ovf_d   = cmsb_q ^ carry_q;
`endif
                end else begin
                    // Operands shift right so the active digit is always at
                    // bit 0; result digits enter the sum from the top, so
                    // after NDIG digits every bit sits in its final place.
                    dsum    = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
                    sum_cat = {dsum[DIGIT-1:0], sum_q};
                    sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    carry_d = dsum[DIGIT];
                    count_d = count_q + CW'(1);
`ifdef SOMADOR_SERIAL_OVF_EN
                    // Carry into the digit's top bit; the value left after
                    // the last digit is the carry into bit WIDTH-1.
                    cmsb_d  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
`endif
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
`ifdef SOMADOR_SERIAL_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
`ifdef SOMADOR_SERIAL_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
